// File: rtl/instruction_encoder_pkg.sv
// Shared definitions for the instruction encoder: RV32I/PIM opcodes, error codes,
// the request bundle carried through the pipeline and a signed range helper.
package instruction_encoder_pkg;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_PIM    = 7'b0001011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  localparam logic [2:0] FUNCT3_SL = 3'b001;
  localparam logic [2:0] FUNCT3_SR = 3'b101;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_RANGE  = 2'd1,
    ERR_ALIGN  = 2'd2,
    ERR_OPCODE = 2'd3
  } err_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } req_t;

  // True when value is representable as a two's-complement number of 'bits' bits:
  // everything above the sign bit must be a copy of it.
  function automatic logic fits_signed(input logic [31:0] value, input int unsigned bits);
    logic signed [31:0] upper;
    upper = $signed(value) >>> (bits - 1);
    return (upper == '0) || (upper == '1);
  endfunction

endpackage

// File: rtl/instruction_encoder_pack.sv
// Combinational format packing: scatters the immediate into the RV32I/PIM word
// layout selected by the opcode and flags range, alignment and opcode errors.
module instr_pack
  import instruction_encoder_pkg::*;
(
  input  req_t        req_i,
  output logic [31:0] instr_o,
  output err_e        err_o
);

  logic [31:0] word;
  logic        is_shift;

  assign is_shift = (req_i.funct3 == FUNCT3_SL) || (req_i.funct3 == FUNCT3_SR);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch.
    word  = '0;
    err_o = ERR_NONE;

    case (req_i.opcode)
      OPCODE_OP: begin
        word = {req_i.funct7, req_i.rs2, req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
      end

      OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR: begin
        if ((req_i.opcode == OPCODE_OP_IMM) && is_shift) begin
          word = {req_i.funct7, req_i.imm[4:0], req_i.rs1, req_i.funct3, req_i.rd,
                  req_i.opcode};
          if (req_i.imm[31:5] != '0) err_o = ERR_RANGE;
        end else begin
          word = {req_i.imm[11:0], req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
          if (!fits_signed(req_i.imm, 12)) err_o = ERR_RANGE;
        end
      end

      OPCODE_STORE, OPCODE_PIM: begin
        word = {req_i.imm[11:5], req_i.rs2, req_i.rs1, req_i.funct3, req_i.imm[4:0],
                req_i.opcode};
        if (!fits_signed(req_i.imm, 12)) err_o = ERR_RANGE;
      end

      OPCODE_BRANCH: begin
        word = {req_i.imm[12], req_i.imm[10:5], req_i.rs2, req_i.rs1, req_i.funct3,
                req_i.imm[4:1], req_i.imm[11], req_i.opcode};
        if (!fits_signed(req_i.imm, 13)) err_o = ERR_RANGE;
        else if (req_i.imm[0])           err_o = ERR_ALIGN;
      end

      OPCODE_JAL: begin
        word = {req_i.imm[20], req_i.imm[10:1], req_i.imm[11], req_i.imm[19:12], req_i.rd,
                req_i.opcode};
        if (!fits_signed(req_i.imm, 21)) err_o = ERR_RANGE;
        else if (req_i.imm[0])           err_o = ERR_ALIGN;
      end

      OPCODE_LUI, OPCODE_AUIPC: begin
        word = {req_i.imm[31:12], req_i.rd, req_i.opcode};
        if (req_i.imm[11:0] != '0) err_o = ERR_ALIGN;
      end

      default: err_o = ERR_OPCODE;
    endcase

    instr_o = (err_o == ERR_NONE) ? word : NOP_INSTR;
  end

endmodule

// File: rtl/instruction_encoder.sv
// Two-stage elastic encoder: S1 captures request fields, S2 holds the packed word
// and error code. Keeps a wrapping encode counter and a saturating error counter.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [6:0]           opcode_i,
  input  logic [4:0]           rd_i,
  input  logic [2:0]           funct3_i,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  input  logic [6:0]           funct7_i,
  input  logic [31:0]          imm_i,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  output logic [31:0]          instr_o,
  output logic [1:0]           err_o,
  output logic [CNT_W-1:0]     enc_count_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  req_t                 req_in;
  req_t                 s1_req_q, s1_req_d;
  logic                 s1_valid_q, s1_valid_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [31:0]          instr_q, instr_d;
  err_e                 err_q, err_d;
  logic [CNT_W-1:0]     enc_cnt_q, enc_cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [31:0]          pack_instr;
  err_e                 pack_err;
  logic                 s2_adv;
  logic                 req_hs;
  logic                 out_hs;

  assign req_in = '{opcode: opcode_i, rd: rd_i, funct3: funct3_i, rs1: rs1_i, rs2: rs2_i,
                    funct7: funct7_i, imm: imm_i};

  // S2 frees up when empty or draining this cycle, so ready ripples back from the consumer.
  assign s2_adv      = !s2_valid_q || instr_ready_i;
  assign req_ready_o = !s1_valid_q || s2_adv;
  assign req_hs      = req_valid_i && req_ready_o;
  assign out_hs      = s2_valid_q && instr_ready_i;

  instr_pack u_pack (
    .req_i   (s1_req_q),
    .instr_o (pack_instr),
    .err_o   (pack_err)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_req_d   = s1_req_q;
    s2_valid_d = s2_valid_q;
    instr_d    = instr_q;
    err_d      = err_q;
    enc_cnt_d  = enc_cnt_q;
    err_cnt_d  = err_cnt_q;

    if (req_hs) begin
      s1_valid_d = 1'b1;
      s1_req_d   = req_in;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        instr_d = pack_instr;
        err_d   = pack_err;
      end
    end

    if (out_hs) begin
      enc_cnt_d = enc_cnt_q + CNT_W'(1);
      if ((err_q != ERR_NONE) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments only; next-state math lives in always_comb.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      instr_q    <= '0;
      err_q      <= ERR_NONE;
      enc_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      instr_q    <= instr_d;
      err_q      <= err_d;
      enc_cnt_q  <= enc_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // NOTE: the S1 payload is qualified by s1_valid_q, so it carries no reset.
  always_ff @(posedge clk_i) begin
    s1_req_q <= s1_req_d;
  end

  assign instr_valid_o = s2_valid_q;
  assign instr_o       = instr_q;
  assign err_o         = err_q;
  assign enc_count_o   = enc_cnt_q;
  assign err_count_o   = err_cnt_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: directed cases plus randomized requests
// checked against an arithmetic reference model of the RV32I/PIM encodings.
module tb_instruction_encoder;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
  } stim_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  err;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [6:0]  opcode_i;
  logic [4:0]  rd_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [6:0]  funct7_i;
  logic [31:0] imm_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [1:0]  err_o;
  logic [15:0] enc_count_o;
  logic [7:0]  err_count_o;

  exp_t sb_q[$];
  int   out_cyc_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ready_mode = 0;  // 0: consumer stalls, 1: always ready, 2: random

  instruction_encoder #(.CNT_W(16), .ERR_CNT_W(8)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .opcode_i      (opcode_i),
    .rd_i          (rd_i),
    .funct3_i      (funct3_i),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .funct7_i      (funct7_i),
    .imm_i         (imm_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .err_o         (err_o),
    .enc_count_o   (enc_count_o),
    .err_count_o   (err_count_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: field placement via shifts and masks, ranges via signed integers.
  function automatic exp_t ref_encode(input stim_t s);
    longint v;
    logic [31:0] w;
    logic [31:0] m;
    int e;
    exp_t r;
    v = longint'($signed(s.imm));
    m = s.imm;
    w = 32'h0;
    e = 0;
    case (s.op)
      7'b0110011:
        w = (32'(s.f7) << 25) | (32'(s.rs2) << 20) | (32'(s.rs1) << 15) | (32'(s.f3) << 12) |
            (32'(s.rd) << 7) | 32'(s.op);
      7'b0010011, 7'b0000011, 7'b1100111: begin
        if (s.op == 7'b0010011 && (s.f3 == 3'd1 || s.f3 == 3'd5)) begin
          if (v < 0 || v > 31) e = 1;
          w = (32'(s.f7) << 25) | ((m & 32'd31) << 20);
        end else begin
          if (v < -2048 || v > 2047) e = 1;
          w = (m & 32'hFFF) << 20;
        end
        w = w | (32'(s.rs1) << 15) | (32'(s.f3) << 12) | (32'(s.rd) << 7) | 32'(s.op);
      end
      7'b0100011, 7'b0001011: begin
        if (v < -2048 || v > 2047) e = 1;
        w = (((m >> 5) & 32'h7F) << 25) | (32'(s.rs2) << 20) | (32'(s.rs1) << 15) |
            (32'(s.f3) << 12) | ((m & 32'h1F) << 7) | 32'(s.op);
      end
      7'b1100011: begin
        if (v < -4096 || v > 4095) e = 1;
        else if (m % 2 != 0) e = 2;
        w = (((m >> 12) & 32'h1) << 31) | (((m >> 5) & 32'h3F) << 25) | (32'(s.rs2) << 20) |
            (32'(s.rs1) << 15) | (32'(s.f3) << 12) | (((m >> 1) & 32'hF) << 8) |
            (((m >> 11) & 32'h1) << 7) | 32'(s.op);
      end
      7'b1101111: begin
        if (v < -1048576 || v > 1048575) e = 1;
        else if (m % 2 != 0) e = 2;
        w = (((m >> 20) & 32'h1) << 31) | (((m >> 1) & 32'h3FF) << 21) |
            (((m >> 11) & 32'h1) << 20) | (((m >> 12) & 32'hFF) << 12) |
            (32'(s.rd) << 7) | 32'(s.op);
      end
      7'b0110111, 7'b0010111: begin
        if (m % 4096 != 0) e = 2;
        w = (m & 32'hFFFF_F000) | (32'(s.rd) << 7) | 32'(s.op);
      end
      default: e = 3;
    endcase
    if (e != 0) w = 32'h0000_0013;
    r.instr = w;
    r.err   = 2'(e);
    return r;
  endfunction

  function automatic stim_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [6:0] f7, input logic [31:0] imm);
    stim_t s;
    s.op = op; s.rd = rd; s.f3 = f3; s.rs1 = rs1; s.rs2 = rs2; s.f7 = f7; s.imm = imm;
    return s;
  endfunction

  function automatic exp_t ex(input logic [31:0] instr, input logic [1:0] err);
    exp_t e;
    e.instr = instr;
    e.err   = err;
    return e;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rd  = 5'($urandom);
    s.f3  = 3'($urandom);
    s.rs1 = 5'($urandom);
    s.rs2 = 5'($urandom);
    s.f7  = 7'($urandom);
    case ($urandom_range(0, 12))
      0:       s.op = 7'b0110011;
      1, 2:    s.op = 7'b0010011;
      3:       s.op = 7'b0000011;
      4:       s.op = 7'b1100111;
      5:       s.op = 7'b0100011;
      6:       s.op = 7'b0001011;
      7:       s.op = 7'b1100011;
      8:       s.op = 7'b1101111;
      9:       s.op = 7'b0110111;
      10:      s.op = 7'b0010111;
      11:      s.op = 7'b1111111;
      default: s.op = 7'b1011011;
    endcase
    case ($urandom_range(0, 3))
      0: s.imm = 32'($signed($urandom_range(0, 80)) - 40);
      1: begin
        case ($urandom_range(0, 15))
          0:  s.imm = -32'sd4097;
          1:  s.imm = -32'sd4096;
          2:  s.imm = -32'sd2049;
          3:  s.imm = -32'sd2048;
          4:  s.imm = 32'd2047;
          5:  s.imm = 32'd2048;
          6:  s.imm = 32'd4094;
          7:  s.imm = 32'd4096;
          8:  s.imm = 32'd31;
          9:  s.imm = 32'd32;
          10: s.imm = -32'sd1048576;
          11: s.imm = 32'd1048574;
          12: s.imm = 32'd1048576;
          13: s.imm = -32'sd1048578;
          14: s.imm = -32'sd1;
          default: s.imm = 32'd0;
        endcase
      end
      2: s.imm = $urandom;
      default: s.imm = $urandom & 32'hFFFF_F000;
    endcase
    return s;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Offer one request; the expected response is queued at the handshake it lands on.
  task automatic send(input stim_t s, input exp_t e);
    int  waited;
    bit  hs;
    waited = 0;
    hs = 1'b0;
    opcode_i = s.op; rd_i = s.rd; funct3_i = s.f3; rs1_i = s.rs1; rs2_i = s.rs2;
    funct7_i = s.f7; imm_i = s.imm;
    req_valid_i = 1'b1;
    while (!hs && waited < 1000) begin
      @(negedge clk_i);
      hs = req_ready_o;
      if (hs) sb_q.push_back(e);
      step();
      waited++;
    end
    check("req_accept", 32'(hs), 32'd1);
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 1000) begin
      @(posedge clk_i);
      w++;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    req_valid_i = 1'b0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  // Consumer ready, applied shortly after each rising edge.
  initial begin
    instr_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #2;
      case (ready_mode)
        0:       instr_ready_i = 1'b0;
        1:       instr_ready_i = 1'b1;
        default: instr_ready_i = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake, checks hold during stalls.
  initial begin
    int          model_enc;
    int          model_err;
    bit          stall_prev;
    logic [31:0] prev_instr;
    logic [1:0]  prev_err;
    exp_t        e;
    model_enc = 0;
    model_err = 0;
    stall_prev = 1'b0;
    prev_instr = '0;
    prev_err = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        sb_q.delete();
        model_enc = 0;
        model_err = 0;
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && instr_valid_o) begin
          check("hold_instr", instr_o, prev_instr);
          check("hold_err", 32'(err_o), 32'(prev_err));
        end
        if (instr_valid_o && instr_ready_i) begin
          check("enc_count", 32'(enc_count_o), 32'(model_enc % 65536));
          check("err_count", 32'(err_count_o), 32'((model_err > 255) ? 255 : model_err));
          check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("instr", instr_o, e.instr);
            check("err", 32'(err_o), 32'(e.err));
            model_enc++;
            if (e.err != 2'd0) model_err++;
          end
          out_cyc_q.push_back(cyc);
        end
        stall_prev = instr_valid_o && !instr_ready_i;
        prev_instr = instr_o;
        prev_err   = err_o;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    opcode_i = '0; rd_i = '0; funct3_i = '0; rs1_i = '0; rs2_i = '0; funct7_i = '0; imm_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_enc_count", 32'(enc_count_o), 32'd0);
    check("rst_err_count", 32'(err_count_o), 32'd0);
    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    step();

    // ADDI x1,x0,-1 and its latency
    ready_mode = 1;
    send(mk(7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF), ex(32'hFFF0_0093, 2'd0));
    check("lat_s1_only", 32'(instr_valid_o), 32'd0);
    step();
    check("lat_s2_valid", 32'(instr_valid_o), 32'd1);
    drain();
    step();

    // Back-to-back, full throughput
    do_reset();
    ready_mode = 1;
    out_cyc_q.delete();
    send(mk(7'b0100011, 5'd0, 3'b010, 5'd1, 5'd2, 7'd0, 32'd8), ex(32'h0020_A423, 2'd0));
    send(mk(7'b1100011, 5'd0, 3'b000, 5'd0, 5'd0, 7'd0, -32'sd4), ex(32'hFE00_0EE3, 2'd0));
    send(mk(7'b1101111, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'd2048), ex(32'h0010_00EF, 2'd0));
    send(mk(7'b0010011, 5'd5, 3'b101, 5'd5, 5'd0, 7'b0100000, 32'd3), ex(32'h4032_D293, 2'd0));
    drain();
    check("b2b_outputs", 32'(out_cyc_q.size()), 32'd4);
    if (out_cyc_q.size() == 4) check("b2b_span", 32'(out_cyc_q[3] - out_cyc_q[0]), 32'd3);
    check("b2b_enc_count", 32'(enc_count_o), 32'd4);
    step();

    // Error cases
    do_reset();
    ready_mode = 1;
    send(mk(7'b1101111, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'd3), ex(32'h0000_0013, 2'd2));
    send(mk(7'b1100011, 5'd0, 3'b000, 5'd1, 5'd2, 7'd0, 32'd4096), ex(32'h0000_0013, 2'd1));
    send(mk(7'b1111111, 5'd3, 3'b000, 5'd1, 5'd2, 7'd0, 32'd0), ex(32'h0000_0013, 2'd3));
    drain();
    check("errs_err_count", 32'(err_count_o), 32'd3);
    step();

    // Backpressure: two accepted, third refused until the consumer drains
    do_reset();
    ready_mode = 0;
    @(posedge clk_i);
    #1;
    send(mk(7'b0110011, 5'd4, 3'b000, 5'd5, 5'd6, 7'd0, 32'd0), ex(32'h0062_8233, 2'd0));
    send(mk(7'b0110111, 5'd7, 3'b000, 5'd0, 5'd0, 7'd0, 32'h1234_5000), ex(32'h1234_53B7, 2'd0));
    s = mk(7'b0010011, 5'd3, 3'b000, 5'd3, 5'd0, 7'd0, 32'd5);
    opcode_i = s.op; rd_i = s.rd; funct3_i = s.f3; rs1_i = s.rs1; funct7_i = s.f7; imm_i = s.imm;
    req_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("bp_req_ready", 32'(req_ready_o), 32'd0);
      check("bp_valid", 32'(instr_valid_o), 32'd1);
    end
    step();
    ready_mode = 1;
    send(s, ex(32'h0051_8193, 2'd0));
    drain();
    check("bp_enc_count", 32'(enc_count_o), 32'd3);
    step();

    // Reset with both stages full
    ready_mode = 0;
    @(posedge clk_i);
    #1;
    send(mk(7'b0110011, 5'd1, 3'b000, 5'd2, 5'd3, 7'd0, 32'd0), ex(32'h0031_00B3, 2'd0));
    send(mk(7'b0110011, 5'd2, 3'b000, 5'd2, 5'd3, 7'd0, 32'd0), ex(32'h0031_0133, 2'd0));
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("mid_rst_valid", 32'(instr_valid_o), 32'd0);
    check("mid_rst_enc_count", 32'(enc_count_o), 32'd0);
    check("mid_rst_err_count", 32'(err_count_o), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready_o), 32'd1);
    step();
    ready_mode = 1;
    send(mk(7'b0010011, 5'd3, 3'b000, 5'd3, 5'd0, 7'd0, 32'd5), ex(32'h0051_8193, 2'd0));
    drain();
    check("mid_rst_enc_after", 32'(enc_count_o), 32'd1);
    step();

    // Randomized traffic with random backpressure
    do_reset();
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      s = rand_stim();
      send(s, ref_encode(s));
    end
    ready_mode = 1;
    drain();
    check("rand_enc_count", 32'(enc_count_o), 32'd400);
    step();

    // Error counter saturation
    do_reset();
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      s = rand_stim();
      s.op = 7'b1111111;
      send(s, ex(32'h0000_0013, 2'd3));
    end
    drain();
    check("sat_err_count", 32'(err_count_o), 32'd255);
    check("sat_enc_count", 32'(enc_count_o), 32'd300);

    check("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Packs decoded instruction fields plus a full 32-bit immediate back into a 32-bit RV32I/PIM instruction word.
- It is the inverse of the core's immediate generation and field decoding.
- It sits in the debug/boot path so that the debug module and the boot loader can inject instructions into the core fetch stream.
- It is a 2-stage elastic pipeline with valid/ready handshakes on both sides. It range-checks immediates and keeps running encode and error counters.

Parameters:
- CNT_W, 16, width of the encoded-instruction counter. The counter wraps.
- ERR_CNT_W, 8, width of the error counter. The counter saturates.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  encoder can accept a request
- opcode_i  in  7  opcode
- rd_i  in  5  destination register
- funct3_i  in  3  funct3
- rs1_i  in  5  source register 1
- rs2_i  in  5  source register 2
- funct7_i  in  7  funct7; used for R-type and for shift-immediate only
- imm_i  in  32  signed immediate value; byte offset for B/J, full value for U
- instr_valid_o  out  1  encoded word valid
- instr_ready_i  in  1  consumer accepts the word
- instr_o  out  32  encoded instruction
- err_o  out  2  error code: 0 ok, 1 immediate out of range, 2 misaligned, 3 illegal opcode
- enc_count_o  out  CNT_W  count of output handshakes; wraps
- err_count_o  out  ERR_CNT_W  count of output handshakes with err_o != 0; saturates at all-ones

Behaviour:
- Reset: both stage valids are 0, instr_valid_o=0, instr_o=0, err_o=0, enc_count_o=0, err_count_o=0. Reset asserted mid-operation discards all in-flight requests.
- S1 registers the request fields on a request handshake (req_valid_i && req_ready_o).
- S2 encodes combinationally from S1 and registers instr_o/err_o.
- Stage advance rules:
  - s2_adv = !s2_valid || instr_ready_i.
  - req_ready_o = !s1_valid || s2_adv. This is combinational from instr_ready_i.
- Latency: a request accepted at edge N drives instr_valid_o=1 after edge N+1.
- Throughput is 1 instruction per cycle when there is no backpressure.
- Outputs are held stable while instr_valid_o && !instr_ready_i.
- No request is dropped, and order is preserved.
- Encoding by opcode, using the `OPCODE_*` codes:
  - R (0110011): funct7|rs2|rs1|f3|rd|op.
  - I (0010011), f3=001/101: funct7|imm[4:0]|rs1|f3|rd|op. Error 1 if imm_i is not in 0..31.
  - I (0010011) other f3, LOAD, JALR: imm[11:0]|rs1|f3|rd|op. Range is signed 12-bit.
  - STORE and PIM: imm[11:5]|rs2|rs1|f3|imm[4:0]|op. Range is signed 12-bit.
  - BRANCH: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op. Range is signed 13-bit. Error 2 if imm[0]=1.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op. Range is signed 21-bit. Error 2 if imm[0]=1.
  - LUI/AUIPC: imm[31:12]|rd|op. Error 2 if imm[11:0]!=0.
  - Any other opcode: error 3.
- Error priority: 3 > 1 > 2.
- On any error, instr_o=32'h0000_0013 (NOP) and err_o holds the code.
- Counter updates:
  - enc_count_o increments on each output handshake.
  - err_count_o increments on each output handshake with err_o!=0 and stops at its maximum.
  - A simultaneous request handshake and output handshake both take effect in the same cycle.

Decomposition:
- Opcode constants come from the existing shared opcode header.
- A shared package holds:
  - the err_o enum (ERR_NONE, ERR_RANGE, ERR_ALIGN, ERR_OPCODE);
  - funct3 shift constants FUNCT3_SL=3'b001 and FUNCT3_SR=3'b101;
  - NOP_INSTR=32'h0000_0013.
- One combinational sub-module, instr_pack, does the format packing and range checks. The top module holds the pipeline registers, handshake logic and counters.

Test Plan:
- ADDI x1,x0,-1: op=0010011, f3=000, rd=1, imm=32'hFFFF_FFFF → instr_o=FFF00093, err=0; valid asserts the cycle after the S1 load.
- Back-to-back, with instr_ready_i=1 throughout:
  - SW x2,8(x1) → 0020A423;
  - BEQ x0,x0,-4 → FE000EE3;
  - JAL x1,2048 → 001000EF;
  - SRAI x5,x5,3 with funct7=0100000 → 4032D293.
  - Outputs appear on consecutive cycles and enc_count_o ends at 4.
- Error cases; all three emit 00000013 and err_count_o ends at 3:
  - JAL imm=3 → err=2;
  - BRANCH imm=4096 → err=1;
  - opcode 1111111 → err=3.
- Backpressure: hold instr_ready_i=0 and offer 3 requests → 2 accepted, then req_ready_o=0. instr_o stays stable. Releasing ready yields all 3 in order with no loss or duplicates.
- Reset mid-flight: assert rst_i with both stages full → the next cycle has instr_valid_o=0, counters=0 and req_ready_o=1. A new request then encodes correctly.
- Saturation: force 300 errored handshakes → err_count_o=255 while enc_count_o=300.
